// File: rtl/compare_seq.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle,
// with early exit, signed/unsigned modes and valid/ready handshakes.
module compare_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2,
    parameter int CW    = $clog2(WIDTH/CHUNK)+1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out,
    output logic [CW-1:0]    cycles
);

    localparam int NC = WIDTH / CHUNK;
    localparam logic [CW-1:0] LAST = CW'(NC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] ra, rb;
    logic [CW-1:0]    idx;
    logic [CHUNK-1:0] ca, cb;
    logic             neq, last;
    logic [WIDTH-1:0] msb;

    // Operands shift left each cycle so the active chunk is always on top;
    // the signed offset-binary flip is folded in when the operands latch.
    assign msb  = WIDTH'(sgn) << (WIDTH - 1);
    assign ca   = ra[WIDTH-1 -: CHUNK];
    assign cb   = rb[WIDTH-1 -: CHUNK];
    assign neq  = (ca != cb);
    assign last = (idx == LAST);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN:  if (neq || last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra     <= '0;
            rb     <= '0;
            idx    <= '0;
            out    <= 3'b000;
            cycles <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra     <= a ^ msb;
                        rb     <= b ^ msb;
                        idx    <= '0;
                        cycles <= '0;
                    end
                end
                RUN: begin
                    if (neq) begin
                        out    <= (ca < cb) ? 3'b100 : 3'b001;
                        cycles <= idx + 1'b1;
                    end else if (last) begin
                        out    <= 3'b010;
                        cycles <= idx + 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                        ra  <= ra << CHUNK;
                        rb  <= rb << CHUNK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compare_seq.sv
// Randomized and directed checks of compare_seq against a
// behavioural model, over three parameterisations in lockstep.
module tb_compare_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic sgn = 1'b0;

    logic [7:0] a0 = '0, b0 = '0, a2 = '0, b2 = '0;
    logic [3:0] a1 = '0, b1 = '0;
    logic rdy0, rdy1, rdy2, ov0, ov1, ov2;
    logic [2:0] o0, o1, o2;
    logic [2:0] c0, c1;
    logic [0:0] c2;

    int total = 0;
    int bad = 0;

    compare_seq #(.WIDTH(8), .CHUNK(2)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .a(a0), .b(b0), .sgn(sgn), .out_valid(ov0), .out_ready(out_ready),
        .out(o0), .cycles(c0)
    );

    compare_seq #(.WIDTH(4), .CHUNK(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .a(a1), .b(b1), .sgn(sgn), .out_valid(ov1), .out_ready(out_ready),
        .out(o1), .cycles(c1)
    );

    compare_seq #(.WIDTH(8), .CHUNK(8)) d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .a(a2), .b(b2), .sgn(sgn), .out_valid(ov2), .out_ready(out_ready),
        .out(o2), .cycles(c2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_out(input int w, input int x,
                                           input int y, input bit s);
        int xv, yv;
        xv = x;
        yv = y;
        if (s) begin
            if (x >= (1 << (w - 1))) xv = x - (1 << w);
            if (y >= (1 << (w - 1))) yv = y - (1 << w);
        end
        if (xv < yv) return 3'b100;
        if (xv == yv) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int ref_cyc(input int w, input int c,
                                   input int x, input int y);
        int n, m, sh;
        n = w / c;
        m = (1 << c) - 1;
        for (int i = 0; i < n; i++) begin
            sh = w - (i + 1) * c;
            if (((x >> sh) & m) != ((y >> sh) & m)) return i + 1;
        end
        return n;
    endfunction

    task automatic xact(input logic [7:0] x8, input logic [7:0] y8,
                        input logic [3:0] x4, input logic [3:0] y4,
                        input logic s, input int hold);
        logic [2:0] e0, e1, e2;
        int k0, k1, k2, l0, l1, l2;
        e0 = ref_out(8, int'(x8), int'(y8), s);
        e1 = ref_out(4, int'(x4), int'(y4), s);
        e2 = e0;
        k0 = ref_cyc(8, 2, int'(x8), int'(y8));
        k1 = ref_cyc(4, 1, int'(x4), int'(y4));
        k2 = ref_cyc(8, 8, int'(x8), int'(y8));
        a0 = x8; b0 = y8; a2 = x8; b2 = y8;
        a1 = x4; b1 = y4; sgn = s;
        in_valid = 1'b1;
        chk("acc_rdy", 32'({rdy0, rdy1, rdy2}), 32'h7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a0 = 8'($urandom); b0 = 8'($urandom);
        a1 = 4'($urandom); b1 = 4'($urandom);
        sgn = ~s;
        chk("run_rdy", 32'(rdy0), 32'h0);
        l0 = -1; l1 = -1; l2 = -1;
        for (int n = 1; n <= 12 && (l0 < 0 || l1 < 0 || l2 < 0); n++) begin
            @(posedge clk);
            #1;
            if (ov0 && l0 < 0) l0 = n;
            if (ov1 && l1 < 0) l1 = n;
            if (ov2 && l2 < 0) l2 = n;
        end
        chk("lat0", 32'(l0), 32'(k0));
        chk("lat1", 32'(l1), 32'(k1));
        chk("lat2", 32'(l2), 32'(k2));
        chk("out0", 32'(o0), 32'(e0));
        chk("out1", 32'(o1), 32'(e1));
        chk("out2", 32'(o2), 32'(e2));
        chk("cyc0", 32'(c0), 32'(k0));
        chk("cyc1", 32'(c1), 32'(k1));
        chk("cyc2", 32'(c2), 32'(k2));
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                in_valid = 1'b1;
                a0 = 8'hFF;
            end
            if (h == 3) in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("hold_out", 32'(o0), 32'(e0));
            chk("hold_cyc", 32'(c0), 32'(k0));
            chk("hold_rdy", 32'(rdy0), 32'h0);
            chk("hold_ov", 32'(ov0), 32'h1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("ack_ov", 32'({ov0, ov1, ov2}), 32'h0);
        chk("ack_rdy", 32'({rdy0, rdy1, rdy2}), 32'h7);
        chk("ack_keep", 32'(o0), 32'(e0));
    endtask

    initial begin
        logic [7:0] x, y;
        #2;
        chk("rst_rdy", 32'(rdy0), 32'h1);
        chk("rst_ov", 32'(ov0), 32'h0);
        chk("rst_out", 32'(o0), 32'h0);
        chk("rst_cyc", 32'(c0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle", 32'({rdy0, ov0, o0, c0}), 32'({1'b1, 1'b0, 3'b0, 3'b0}));

        xact(8'h30, 8'h10, 4'h3, 4'h1, 1'b0, 0);
        chk("d_30_10", 32'({o0, c0}), 32'({3'b001, 3'd2}));
        xact(8'h80, 8'h7F, 4'h8, 4'h7, 1'b0, 0);
        chk("d_80_u", 32'({o0, c0}), 32'({3'b001, 3'd1}));
        xact(8'h80, 8'h7F, 4'h8, 4'h7, 1'b1, 0);
        chk("d_80_s", 32'({o0, c0}), 32'({3'b100, 3'd1}));
        xact(8'h5A, 8'h5A, 4'h5, 4'h5, 1'b0, 0);
        chk("d_5a_u", 32'({o0, c0}), 32'({3'b010, 3'd4}));
        xact(8'h5A, 8'h5A, 4'h5, 4'h5, 1'b1, 0);
        chk("d_5a_s", 32'({o0, c0}), 32'({3'b010, 3'd4}));
        xact(8'h01, 8'h02, 4'h1, 4'h2, 1'b0, 5);
        chk("d_bp", 32'({o0, c0}), 32'({3'b100, 3'd4}));

        // abandon a compare mid-run
        a0 = 8'h5A; b0 = 8'h5A; a1 = 4'h0; b1 = 4'h0;
        a2 = 8'h00; b2 = 8'h00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst", 32'({rdy0, ov0, o0, c0}),
            32'({1'b1, 1'b0, 3'b0, 3'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_nores", 32'({ov0, rdy0}), 32'({1'b0, 1'b1}));

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    x = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) y = x;
                    else y = x ^ (8'h01 << $urandom_range(0, 7));
                    if ($urandom_range(0, 3) == 0) y = 8'($urandom);
                    xact(x, y, 4'(i), 4'(j), 1'(s), $urandom_range(0, 2));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
